// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared state, opcode and ALU-control encodings for the multi-cycle RV64 control path.
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, BRANCH, ILLEGAL
  } state_e;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;
  function automatic logic is_mem_state(input state_e s);
    return s inside {FETCH, MEM_READ, MEM_WRITE};
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts mem_ready=0 cycles in a memory state and flags a timeout on the last allowed cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);
  localparam int W = MEM_TIMEOUT > 2 ? $clog2(MEM_TIMEOUT) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clear ? '0 : (active && !mem_ready) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // a same-cycle mem_ready completes normally instead of faulting
  assign timeout = (MEM_TIMEOUT != 0) && active && !mem_ready && (cnt_q == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: main control FSM of the multi-cycle RV64 datapath with retire counter and memory timeout.
module multi_cycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_instr,
  output logic             mem_fault,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);
  state_e state_q, state_d, boundary;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic timeout;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_d != state_q),
    .active   (is_mem_state(state_q)),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );
  assign boundary = run ? FETCH : IDLE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = run ? FETCH : IDLE;
      FETCH:     state_d = timeout ? IDLE : mem_ready ? DECODE : FETCH;
      DECODE:    state_d = opcode == OP_RTYPE ? EXECUTE :
                           (opcode == OP_LOAD || opcode == OP_STORE) ? MEM_ADDR :
                           opcode == OP_BRANCH ? BRANCH : ILLEGAL;
      MEM_ADDR:  state_d = opcode == OP_LOAD ? MEM_READ : MEM_WRITE;
      MEM_READ:  state_d = timeout ? IDLE : mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = timeout ? IDLE : mem_ready ? boundary : MEM_WRITE;
      EXECUTE:   state_d = R_WB;
      MEM_WB, R_WB, BRANCH, ILLEGAL: state_d = boundary;
      default:   state_d = IDLE;
    endcase
  end
  assign retired_d = retired_q + CNT_W'(instr_done);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  assign pc_write      = state_q == FETCH && mem_ready;
  assign ir_write      = state_q == FETCH && mem_ready;
  assign pc_write_cond = state_q == BRANCH;
  assign pc_source     = state_q == BRANCH;
  assign i_or_d        = state_q inside {MEM_READ, MEM_WRITE};
  assign mem_read      = state_q inside {FETCH, MEM_READ};
  assign mem_write     = state_q == MEM_WRITE;
  assign mem_to_reg    = state_q == MEM_WB;
  assign reg_write     = state_q inside {MEM_WB, R_WB};
  assign alu_src_a     = state_q inside {MEM_ADDR, EXECUTE, BRANCH};
  assign alu_src_b     = state_q == FETCH ? SRCB_FOUR : state_q == DECODE ? SRCB_BOFF :
                         state_q == MEM_ADDR ? SRCB_IMM : SRCB_REG;
  assign alu_op        = state_q == EXECUTE ? ALUOP_FUNCT : state_q == BRANCH ? ALUOP_SUB : ALUOP_ADD;
  assign illegal_instr = state_q == ILLEGAL;
  assign mem_fault     = timeout;
  assign instr_done    = state_q inside {MEM_WB, R_WB, BRANCH} || (state_q == MEM_WRITE && mem_ready);
  assign retired       = retired_q;
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: directed per-cycle vectors queued by the stimulus and checked by a negedge monitor.
module tb_multi_cycle_control;
  logic clk = 0, rst_n = 0, run = 0, mem_ready = 0;
  logic [6:0] opcode = '0;
  logic pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_write, alu_src_a, illegal_instr, mem_fault, instr_done;
  logic [1:0] alu_src_b, alu_op;
  logic [31:0] retired;
  logic [16:0] obs;
  always #5 clk = ~clk;
  multi_cycle_control #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_instr(illegal_instr),
    .mem_fault(mem_fault), .instr_done(instr_done), .retired(retired)
  );
  assign obs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_instr, mem_fault, instr_done};
  localparam logic [6:0] R = 7'b0110011, LD = 7'b0000011, SD = 7'b0100011, BQ = 7'b1100011, BAD = 7'b1111111;
  localparam logic [16:0] B_PCW = 17'd1 << 16, B_PWC = 17'd1 << 15, B_PSRC = 17'd1 << 14;
  localparam logic [16:0] B_IORD = 17'd1 << 13, B_MRD = 17'd1 << 12, B_MWR = 17'd1 << 11;
  localparam logic [16:0] B_IRW = 17'd1 << 10, B_M2R = 17'd1 << 9, B_RW = 17'd1 << 8, B_ASA = 17'd1 << 7;
  localparam logic [16:0] SB_4 = 17'd1 << 5, SB_IMM = 17'd2 << 5, SB_BOFF = 17'd3 << 5;
  localparam logic [16:0] AOP_SUB = 17'd1 << 3, AOP_FN = 17'd2 << 3;
  localparam logic [16:0] B_ILL = 17'd1 << 2, B_FLT = 17'd1 << 1, B_DONE = 17'd1;
  localparam logic [16:0] E_IDLE = '0;
  localparam logic [16:0] E_FETCH_W = B_MRD | SB_4;
  localparam logic [16:0] E_FETCH_R = E_FETCH_W | B_PCW | B_IRW;
  localparam logic [16:0] E_DEC = SB_BOFF;
  localparam logic [16:0] E_MADDR = B_ASA | SB_IMM;
  localparam logic [16:0] E_MRD = B_MRD | B_IORD;
  localparam logic [16:0] E_MWB = B_RW | B_M2R | B_DONE;
  localparam logic [16:0] E_MWR_W = B_MWR | B_IORD;
  localparam logic [16:0] E_MWR_R = E_MWR_W | B_DONE;
  localparam logic [16:0] E_EXE = B_ASA | AOP_FN;
  localparam logic [16:0] E_RWB = B_RW | B_DONE;
  localparam logic [16:0] E_BR = B_ASA | AOP_SUB | B_PWC | B_PSRC | B_DONE;
  localparam logic [16:0] E_ILL = B_ILL;
  localparam logic [16:0] E_FAULT = E_FETCH_W | B_FLT;
  typedef struct {
    logic [16:0] o;
    logic [31:0] r;
    int          n;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, step = 0;
  logic [31:0] exp_ret = '0;
  task automatic st(input logic rs, input logic r, input logic [6:0] op, input logic mr, input logic [16:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rs;
    run = r;
    opcode = op;
    mem_ready = mr;
    if (!rs) exp_ret = '0;
    step++;
    x.o = e;
    x.r = exp_ret;
    x.n = step;
    q.push_back(x);
    if (e[0]) exp_ret++;
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if (obs !== x.o) begin
        errors++;
        $display("FAIL outputs step %0d: got %b expected %b", x.n, obs, x.o);
      end
      checks++;
      if (retired !== x.r) begin
        errors++;
        $display("FAIL retired step %0d: got %0d expected %0d", x.n, retired, x.r);
      end
    end
  end
  initial begin
    st(0, 0, R, 1, E_IDLE);
    st(0, 0, R, 1, E_IDLE);
    // R-type, zero-wait
    st(1, 1, R, 1, E_IDLE);
    st(1, 1, R, 1, E_FETCH_R);
    st(1, 1, R, 1, E_DEC);
    st(1, 1, R, 1, E_EXE);
    st(1, 1, R, 1, E_RWB);
    // ld with two wait cycles in MEM_READ
    st(1, 1, LD, 1, E_FETCH_R);
    st(1, 1, LD, 1, E_DEC);
    st(1, 1, LD, 1, E_MADDR);
    st(1, 1, LD, 0, E_MRD);
    st(1, 1, LD, 0, E_MRD);
    st(1, 1, LD, 1, E_MRD);
    st(1, 1, LD, 1, E_MWB);
    // beq
    st(1, 1, BQ, 1, E_FETCH_R);
    st(1, 1, BQ, 1, E_DEC);
    st(1, 1, BQ, 1, E_BR);
    // illegal opcode
    st(1, 1, BAD, 1, E_FETCH_R);
    st(1, 1, BAD, 1, E_DEC);
    st(1, 1, BAD, 1, E_ILL);
    // sd with one fetch wait
    st(1, 1, SD, 0, E_FETCH_W);
    st(1, 1, SD, 1, E_FETCH_R);
    st(1, 1, SD, 1, E_DEC);
    st(1, 1, SD, 1, E_MADDR);
    st(1, 1, SD, 1, E_MWR_R);
    // run dropped mid-instruction
    st(1, 1, R, 1, E_FETCH_R);
    st(1, 1, R, 1, E_DEC);
    st(1, 0, R, 1, E_EXE);
    st(1, 0, R, 1, E_RWB);
    st(1, 0, R, 1, E_IDLE);
    st(1, 1, BQ, 0, E_IDLE);
    // mem_ready on the last allowed cycle wins over timeout
    st(1, 1, BQ, 0, E_FETCH_W);
    st(1, 1, BQ, 0, E_FETCH_W);
    st(1, 1, BQ, 0, E_FETCH_W);
    st(1, 1, BQ, 1, E_FETCH_R);
    st(1, 1, BQ, 1, E_DEC);
    st(1, 1, BQ, 1, E_BR);
    // timeout in FETCH
    st(1, 1, R, 0, E_FETCH_W);
    st(1, 1, R, 0, E_FETCH_W);
    st(1, 1, R, 0, E_FETCH_W);
    st(1, 1, R, 0, E_FAULT);
    st(1, 0, R, 0, E_IDLE);
    // reset in the middle of MEM_WRITE
    st(1, 1, SD, 1, E_IDLE);
    st(1, 1, SD, 1, E_FETCH_R);
    st(1, 1, SD, 1, E_DEC);
    st(1, 1, SD, 0, E_MADDR);
    st(1, 1, SD, 0, E_MWR_W);
    st(0, 1, SD, 0, E_IDLE);
    st(1, 0, SD, 0, E_IDLE);
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
